// File: rtl/sdrd_recirc_entry_buf.sv
// sdrd_recirc_entry_buf: picture-entry FIFO with a recirculate mode.
// In recirc mode a popped entry is written back at the tail in the same cycle,
// so the picture list replays forever without the parser rewriting it.
// Optional feature macro: SDRD_ENTRYBUF_ERRFLAG_EN adds sticky o_err[1:0]
// (bit 0 = read while empty, bit 1 = refused write).
module sdrd_recirc_entry_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_recirc,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_valid,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_wr_rej,
`ifdef SDRD_ENTRYBUF_ERRFLAG_EN
  output logic                     o_lap,
  output logic [1:0]               o_err
`else
  output logic                     o_lap
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_count;
  logic [AW:0]      r_lap_cnt;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_rc_pop;
  logic             w_cons_pop;
  logic             w_push;
  logic             w_rej;
  logic             w_we;
  logic [WIDTH-1:0] w_wdata;
  logic             w_lap_hit;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = i_rd & ~w_empty & ~i_clr;
  assign w_rc_pop   = w_pop & i_recirc;
  assign w_cons_pop = w_pop & ~i_recirc;

  // Recirc mode owns the tail write port on a pop, so a concurrent WR loses.
  // Consume mode lets a WR into a full buffer when a pop frees the slot.
  assign w_push = i_wr & ~i_clr & (i_recirc ? (~w_pop & ~w_full) : (~w_full | w_pop));
  assign w_rej  = i_wr & ~i_clr & ~w_push;

  // While full wp==rp, so a recirc rewrite lands on the slot just read.
  assign w_we      = (w_push | w_rc_pop) & ~i_rst;
  assign w_wdata   = w_rc_pop ? r_mem[r_rp] : i_din;
  assign w_lap_hit = w_rc_pop & (r_lap_cnt == (r_count - CNT_ONE));

  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_count = r_count;

  // Entry storage: not reset, pointers define what is live.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[r_wp] <= w_wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_we) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      if (w_push & ~w_cons_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (~w_push & w_cons_pop) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // Lap counter: counts recirc pops since the list last changed shape.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lap_cnt <= '0;
    end else if (i_clr || w_push || w_cons_pop) begin
      r_lap_cnt <= '0;
    end else if (w_rc_pop) begin
      r_lap_cnt <= w_lap_hit ? '0 : (r_lap_cnt + CNT_ONE);
    end
  end

  // Registered read data and status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dout   <= '0;
      o_valid  <= 1'b0;
      o_wr_rej <= 1'b0;
      o_lap    <= 1'b0;
    end else if (i_clr) begin
      o_valid  <= 1'b0;
      o_wr_rej <= 1'b0;
      o_lap    <= 1'b0;
    end else begin
      if (w_pop) begin
        o_dout <= r_mem[r_rp];
      end
      o_valid  <= w_pop;
      o_wr_rej <= w_rej;
      o_lap    <= w_lap_hit;
    end
  end

`ifdef SDRD_ENTRYBUF_ERRFLAG_EN
  // Sticky error flags, cleared only by CLR or reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err <= 2'b00;
    end else if (i_clr) begin
      o_err <= 2'b00;
    end else begin
      o_err <= o_err | {w_rej, i_rd & w_empty};
    end
  end
`endif

endmodule

// File: tb/tb_sdrd_recirc_entry_buf.sv
// Testbench for sdrd_recirc_entry_buf: directed scenarios plus randomized
// traffic, checked against a queue-based reference model.
module tb_sdrd_recirc_entry_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 128;

  logic              clk;
  logic              rst;
  logic              i_clr;
  logic              i_recirc;
  logic              i_wr;
  logic [WIDTH-1:0]  i_din;
  logic              i_rd;
  logic [WIDTH-1:0]  o_dout;
  logic              o_valid;
  logic              o_empty;
  logic              o_full;
  logic [7:0]        o_count;
  logic              o_wr_rej;
  logic              o_lap;
`ifdef SDRD_ENTRYBUF_ERRFLAG_EN
  logic [1:0]        o_err;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid;
  logic             m_rej;
  logic             m_lap;
  int               m_lap_cnt;
  logic [1:0]       m_err;

  sdrd_recirc_entry_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clr    (i_clr),
    .i_recirc (i_recirc),
    .i_wr     (i_wr),
    .i_din    (i_din),
    .i_rd     (i_rd),
    .o_dout   (o_dout),
    .o_valid  (o_valid),
    .o_empty  (o_empty),
    .o_full   (o_full),
    .o_count  (o_count),
    .o_wr_rej (o_wr_rej),
`ifdef SDRD_ENTRYBUF_ERRFLAG_EN
    .o_lap    (o_lap),
    .o_err    (o_err)
`else
    .o_lap    (o_lap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_reset();
    q.delete();
    m_dout = '0; m_valid = 0; m_rej = 0; m_lap = 0; m_lap_cnt = 0; m_err = 2'b00;
  endtask

  // One clock of the FIFO described as list operations.
  task automatic m_step(input logic clr, input logic rec, input logic wr,
                        input logic [WIDTH-1:0] din, input logic rd);
    int cnt;
    logic pop;
    logic rej;
    logic [WIDTH-1:0] x;
    if (clr) begin
      q.delete();
      m_valid = 0; m_rej = 0; m_lap = 0; m_lap_cnt = 0; m_err = 2'b00;
      return;
    end
    cnt = q.size();
    pop = rd && (cnt != 0);
    rej = 0;
    m_lap = 0;
    if (rd && cnt == 0) m_err[0] = 1'b1;
    if (rec) begin
      if (pop) begin
        x = q.pop_front();
        q.push_back(x);
        m_dout = x;
        rej = wr;
        if (m_lap_cnt == cnt - 1) begin
          m_lap = 1; m_lap_cnt = 0;
        end else begin
          m_lap_cnt++;
        end
      end else if (wr) begin
        if (cnt < DEPTH) begin q.push_back(din); m_lap_cnt = 0; end
        else rej = 1;
      end
    end else begin
      if (pop) begin m_dout = q.pop_front(); m_lap_cnt = 0; end
      if (wr) begin
        if (cnt < DEPTH || pop) begin q.push_back(din); m_lap_cnt = 0; end
        else rej = 1;
      end
    end
    m_valid = pop;
    m_rej = rej;
    if (rej) m_err[1] = 1'b1;
  endtask

  // Drive one cycle of inputs, advance model at the edge, return at negedge.
  task automatic cyc(input logic clr, input logic rec, input logic wr,
                     input logic [WIDTH-1:0] din, input logic rd);
    i_clr = clr; i_recirc = rec; i_wr = wr; i_din = din; i_rd = rd;
    @(posedge clk);
    m_step(clr, rec, wr, din, rd);
    @(negedge clk);
    i_clr = 0; i_wr = 0; i_rd = 0;
  endtask

  task automatic test_reset();
    rst = 1; i_clr = 0; i_recirc = 0; i_wr = 0; i_din = '0; i_rd = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (o_dout !== 32'h0) begin bad++; $display("FAIL reset_dout: got %h want 0", o_dout); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", o_empty); end
    total++; if (o_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", o_full); end
    total++; if (o_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", o_count); end
    total++; if (o_wr_rej !== 1'b0 || o_lap !== 1'b0) begin bad++; $display("FAIL reset_pulses: got rej=%b lap=%b want 0 0", o_wr_rej, o_lap); end
    rst = 0;
  endtask

  task automatic test_consume_basic();
    logic [WIDTH-1:0] v [3];
    v[0] = 32'hA; v[1] = 32'hB; v[2] = 32'hC;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, v[i], 0);
    total++; if (o_count !== 8'd3) begin bad++; $display("FAIL basic_count3: got %0d want 3", o_count); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, '0, 1);
      total++; if (o_valid !== 1'b1 || o_dout !== v[i]) begin bad++; $display("FAIL basic_rd%0d: got v=%b d=%h want 1 %h", i, o_valid, o_dout, v[i]); end
      total++; if (o_count !== 8'(2 - i)) begin bad++; $display("FAIL basic_cnt%0d: got %0d want %0d", i, o_count, 2 - i); end
    end
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL basic_empty: got %b want 1", o_empty); end
  endtask

  task automatic test_full();
    logic [WIDTH-1:0] first;
    cyc(1, 0, 0, '0, 0);
    first = $urandom();
    cyc(0, 0, 1, first, 0);
    for (int i = 1; i < DEPTH; i++) cyc(0, 0, 1, $urandom(), 0);
    total++; if (o_full !== 1'b1 || o_count !== 8'd128) begin bad++; $display("FAIL full_fill: got full=%b cnt=%0d want 1 128", o_full, o_count); end
    cyc(0, 0, 1, 32'hDEAD_BEEF, 0);
    total++; if (o_wr_rej !== 1'b1 || o_count !== 8'd128) begin bad++; $display("FAIL full_rej: got rej=%b cnt=%0d want 1 128", o_wr_rej, o_count); end
    cyc(0, 0, 1, 32'h1234_5678, 1);
    total++; if (o_wr_rej !== 1'b0 || o_count !== 8'd128 || o_valid !== 1'b1) begin bad++; $display("FAIL full_wrrd: got rej=%b cnt=%0d v=%b want 0 128 1", o_wr_rej, o_count, o_valid); end
    total++; if (o_dout !== first) begin bad++; $display("FAIL full_wrrd_dout: got %h want %h", o_dout, first); end
  endtask

  task automatic test_recirc();
    logic [WIDTH-1:0] v [4];
    v[0] = 32'hA; v[1] = 32'hB; v[2] = 32'hC; v[3] = 32'hD;
    cyc(1, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, v[i], 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, '0, 1);
      total++; if (o_valid !== 1'b1 || o_dout !== v[i % 4]) begin bad++; $display("FAIL recirc_rd%0d: got v=%b d=%h want 1 %h", i, o_valid, o_dout, v[i % 4]); end
      total++; if (o_lap !== ((i % 4) == 3)) begin bad++; $display("FAIL recirc_lap%0d: got %b want %b", i, o_lap, (i % 4) == 3); end
      total++; if (o_count !== 8'd4) begin bad++; $display("FAIL recirc_cnt%0d: got %0d want 4", i, o_count); end
    end
  endtask

  task automatic test_recirc_collision();
    cyc(0, 1, 1, 32'hEEEE, 1);
    total++; if (o_wr_rej !== 1'b1 || o_count !== 8'd4 || o_dout !== 32'hA) begin bad++; $display("FAIL coll_rej: got rej=%b cnt=%0d d=%h want 1 4 a", o_wr_rej, o_count, o_dout); end
    cyc(0, 1, 1, 32'hE, 0);
    total++; if (o_wr_rej !== 1'b0 || o_count !== 8'd5) begin bad++; $display("FAIL coll_push: got rej=%b cnt=%0d want 0 5", o_wr_rej, o_count); end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, '0, 1);
      total++; if (o_dout !== m_dout || o_lap !== (i == 4)) begin bad++; $display("FAIL coll_rd%0d: got d=%h lap=%b want %h %b", i, o_dout, o_lap, m_dout, i == 4); end
    end
  endtask

  task automatic test_underflow();
    logic [WIDTH-1:0] held;
    cyc(1, 0, 0, '0, 0);
    held = o_dout;
    cyc(0, 0, 0, '0, 1);
    total++; if (o_valid !== 1'b0 || o_dout !== held) begin bad++; $display("FAIL under_rd: got v=%b d=%h want 0 %h", o_valid, o_dout, held); end
`ifdef SDRD_ENTRYBUF_ERRFLAG_EN
    cyc(0, 0, 0, '0, 0);
    total++; if (o_err !== 2'b01) begin bad++; $display("FAIL under_err: got %b want 01", o_err); end
    cyc(1, 0, 0, '0, 0);
    total++; if (o_err !== 2'b00) begin bad++; $display("FAIL under_errclr: got %b want 00", o_err); end
`endif
  endtask

  task automatic test_random();
    logic base_rec;
    logic rec, wr, rd, clr;
    int wr_pct;
    cyc(1, 0, 0, '0, 0);
    for (int ph = 0; ph < 6; ph++) begin
      base_rec = ph[0];
      wr_pct = (ph < 2) ? 90 : 40;
      for (int n = 0; n < 400; n++) begin
        rec = ($urandom_range(0, 9) == 0) ? ~base_rec : base_rec;
        wr  = ($urandom_range(0, 99) < wr_pct);
        rd  = ($urandom_range(0, 99) < 35);
        clr = ($urandom_range(0, 199) == 0);
        cyc(clr, rec, wr, $urandom(), rd);
        total++;
        if (o_dout !== m_dout || o_valid !== m_valid || o_count !== 8'(q.size()) ||
            o_empty !== (q.size() == 0) || o_full !== (q.size() == DEPTH) ||
            o_wr_rej !== m_rej || o_lap !== m_lap) begin
          bad++;
          $display("FAIL rand_p%0d_c%0d: got d=%h v=%b c=%0d e=%b f=%b r=%b l=%b want d=%h v=%b c=%0d r=%b l=%b",
                   ph, n, o_dout, o_valid, o_count, o_empty, o_full, o_wr_rej, o_lap,
                   m_dout, m_valid, q.size(), m_rej, m_lap);
        end
`ifdef SDRD_ENTRYBUF_ERRFLAG_EN
        total++; if (o_err !== m_err) begin bad++; $display("FAIL rand_err_c%0d: got %b want %b", n, o_err, m_err); end
`endif
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 32'h100 + i, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0, 1);
    i_recirc = 1; i_rd = 1;
    #2 rst = 1;
    #1;
    total++; if (o_count !== 8'd0 || o_empty !== 1'b1 || o_valid !== 1'b0 || o_dout !== 32'h0 || o_lap !== 1'b0 || o_wr_rej !== 1'b0) begin
      bad++; $display("FAIL midrst_async: got c=%0d e=%b v=%b d=%h l=%b r=%b want 0 1 0 0 0 0", o_count, o_empty, o_valid, o_dout, o_lap, o_wr_rej);
    end
    @(posedge clk); @(negedge clk);
    total++; if (o_count !== 8'd0 || o_valid !== 1'b0 || o_dout !== 32'h0 || o_full !== 1'b0) begin
      bad++; $display("FAIL midrst_edge: got c=%0d v=%b d=%h f=%b want 0 0 0 0", o_count, o_valid, o_dout, o_full);
    end
    rst = 0; i_rd = 0;
    m_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h200 + i, 0);
    cyc(0, 0, 0, '0, 1);
    cyc(1, 0, 1, 32'h300, 1);
    total++; if (o_count !== 8'd0 || o_empty !== 1'b1 || o_valid !== 1'b0 || o_dout !== 32'h200) begin
      bad++; $display("FAIL clr: got c=%0d e=%b v=%b d=%h want 0 1 0 200", o_count, o_empty, o_valid, o_dout);
    end
  endtask

  initial begin
    test_reset();
    test_consume_basic();
    test_full();
    test_recirc();
    test_recirc_collision();
    test_underflow();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
